// File: rtl/seq_detect_param.sv
// Run-time programmable N-bit serial pattern detector with a registered match flag,
// overlapping/non-overlapping detection and a saturating match counter.
module seq_detect_param #(
   parameter int             N        = 4,
   parameter logic [N-1:0]   PAT_INIT = {N{1'b1}},
   parameter int             CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             en,
   input  logic             w,
   input  logic [N-1:0]     pattern,
   input  logic             load,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FW = $clog2(N + 1);

   logic [N-1:0]  pat_r;
   logic [N-1:0]  hist;
   logic [FW-1:0] fill;

   logic [N-1:0]  new_hist;
   logic [FW-1:0] new_fill;
   logic          hit;

   // fill guards against stale history bits: a window only counts once it holds N fresh samples.
   always_comb begin
      new_hist = {hist[N-2:0], w};
      new_fill = (fill == FW'(N)) ? fill : fill + FW'(1);
      hit      = !load && en && (new_fill == FW'(N)) && (new_hist == pat_r);
   end

   assign cnt_sat = (match_cnt == {CNT_W{1'b1}});

   // NOTE: state registers use non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         pat_r <= PAT_INIT;
         hist  <= '0;
         fill  <= '0;
         y     <= 1'b0;
      end else if (load) begin
         pat_r <= pattern;
         hist  <= '0;
         fill  <= '0;
         y     <= 1'b0;
      end else if (!en) begin
         y     <= 1'b0;
      end else begin
         hist  <= new_hist;
         fill  <= (hit && !overlap) ? '0 : new_fill;
         y     <= hit;
      end
   end

   // Counter is independent of load; a clear wins over a coincident hit.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         match_cnt <= '0;
      end else if (clr_cnt) begin
         match_cnt <= '0;
      end else if (hit && !cnt_sat) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: queue-based reference model checked every cycle on two
// instances (CNT_W=8 and CNT_W=3), plus directed vectors with hand-computed y values.
module tb_seq_detect_param;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rs;
   logic         en = 1'b0;
   logic         w = 1'b0;
   logic [N-1:0] pattern = '0;
   logic         load = 1'b0;
   logic         overlap = 1'b1;
   logic         clr_cnt = 1'b0;

   logic         y_a, sat_a, y_b, sat_b;
   logic [7:0]   cnt_a;
   logic [2:0]   cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   seq_detect_param #(.N(N), .CNT_W(8)) dut (
      .clk(clk), .rs(rs), .en(en), .w(w), .pattern(pattern), .load(load),
      .overlap(overlap), .clr_cnt(clr_cnt), .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
   );

   seq_detect_param #(.N(N), .CNT_W(3)) dut3 (
      .clk(clk), .rs(rs), .en(en), .w(w), .pattern(pattern), .load(load),
      .overlap(overlap), .clr_cnt(clr_cnt), .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: fresh samples since the last restart are kept in a queue;
   // a hit is simply "the last N fresh samples spell the pattern".
   logic [N-1:0] m_pat = '1;
   bit           m_q[$];
   logic         m_y = 1'b0;
   int           m_cnt8 = 0;
   int           m_cnt3 = 0;

   initial begin
      forever begin
         @(posedge clk or posedge rs);
         if (rs) begin
            m_pat = '1; m_q.delete(); m_y = 1'b0; m_cnt8 = 0; m_cnt3 = 0;
         end else begin
            automatic bit hit = 1'b0;
            if (load) begin
               m_pat = pattern; m_q.delete(); m_y = 1'b0;
            end else if (!en) begin
               m_y = 1'b0;
            end else begin
               m_q.push_back(w);
               if (m_q.size() > N) void'(m_q.pop_front());
               if (m_q.size() == N) begin
                  hit = 1'b1;
                  for (int i = 0; i < N; i++)
                     if (m_q[i] != m_pat[N-1-i]) hit = 1'b0;
               end
               m_y = hit;
               if (hit && !overlap) m_q.delete();
            end
            if (clr_cnt) begin
               m_cnt8 = 0; m_cnt3 = 0;
            end else if (hit) begin
               if (m_cnt8 < 255) m_cnt8++;
               if (m_cnt3 < 7)   m_cnt3++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rs === 1'b0) begin
         check("model_y_a",   y_a,   m_y);
         check("model_y_b",   y_b,   m_y);
         check("model_cnt_a", cnt_a, m_cnt8);
         check("model_cnt_b", cnt_b, m_cnt3);
         check("model_sat_a", sat_a, m_cnt8 == 255);
         check("model_sat_b", sat_b, m_cnt3 == 7);
      end
   end

   task automatic send(input logic wv, input logic env, input logic clr,
                       input logic exp_y, input string tag);
      @(negedge clk);
      w = wv; en = env; clr_cnt = clr; load = 1'b0;
      @(posedge clk);
      #1;
      check(tag, y_a, exp_y);
      en = 1'b0; clr_cnt = 1'b0;
   endtask

   task automatic restart(input logic [N-1:0] pat);
      @(negedge clk);
      pattern = pat; load = 1'b1; clr_cnt = 1'b1; en = 1'b1; w = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0; clr_cnt = 1'b0; en = 1'b0;
      check("load_y", y_a, 1'b0);
      check("load_cnt", cnt_a, 0);
   endtask

   task automatic send_seq(input logic [15:0] bits, input logic [15:0] ys,
                           input int len, input string tag);
      for (int i = 0; i < len; i++) send(bits[len-1-i], 1'b1, 1'b0, ys[len-1-i], tag);
   endtask

   initial begin
      rs = 1'b1;
      #1;
      check("rst_y", y_a, 1'b0);
      check("rst_cnt", cnt_a, 0);
      check("rst_sat", sat_a, 1'b0);
      #12;
      rs = 1'b0;

      // Legacy 1111 behaviour, overlapping.
      overlap = 1'b1;
      send_seq(16'b1111110, 16'b0001110, 7, "t1_y");
      check("t1_cnt", cnt_a, 3);

      // Non-overlapping, eight ones.
      restart(4'b1111);
      overlap = 1'b0;
      send_seq(16'b11111111, 16'b00010001, 8, "t2_y");
      check("t2_cnt", cnt_a, 2);

      // Programmed pattern 1011, both modes.
      restart(4'b1011);
      overlap = 1'b1;
      send_seq(16'b1011011, 16'b0001001, 7, "t3o_y");
      check("t3o_cnt", cnt_a, 2);
      restart(4'b1011);
      overlap = 1'b0;
      send_seq(16'b1011011, 16'b0001000, 7, "t3n_y");
      check("t3n_cnt", cnt_a, 1);

      // Disabled edges hold history and force y low.
      restart(4'b1111);
      overlap = 1'b1;
      send(1'b1, 1'b1, 1'b0, 1'b0, "t4_y");
      send(1'b1, 1'b1, 1'b0, 1'b0, "t4_y");
      for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 1'b0, "t4_dis_y");
      send(1'b1, 1'b1, 1'b0, 1'b0, "t4_y");
      send(1'b1, 1'b1, 1'b0, 1'b1, "t4_hit_y");

      // All-zero pattern never matches early on reset history.
      restart(4'b0000);
      send_seq(16'b00000, 16'b00011, 5, "t7_y");

      // Saturation on the 3-bit counter, then clear on a hit edge.
      restart(4'b1111);
      overlap = 1'b1;
      send_seq(16'b1111111111111, 16'b0001111111111, 13, "t5_y");
      check("t5_cnt_b", cnt_b, 7);
      check("t5_sat_b", sat_b, 1'b1);
      check("t5_cnt_a", cnt_a, 10);
      check("t5_sat_a", sat_a, 1'b0);
      send(1'b1, 1'b1, 1'b1, 1'b1, "t5_clr_y");
      check("t5_clr_cnt_b", cnt_b, 0);
      check("t5_clr_sat_b", sat_b, 1'b0);
      check("t5_clr_cnt_a", cnt_a, 0);

      // Asynchronous reset mid-cycle restores PAT_INIT and empties history.
      restart(4'b1011);
      send_seq(16'b1011, 16'b0001, 4, "t6_pre_y");
      check("t6_pre_cnt", cnt_a, 1);
      #2;
      rs = 1'b1;
      #1;
      check("t6_async_y", y_a, 1'b0);
      check("t6_async_cnt", cnt_a, 0);
      check("t6_async_sat", sat_a, 1'b0);
      #1;
      rs = 1'b0;
      send_seq(16'b11111, 16'b00011, 5, "t6_post_y");
      check("t6_post_cnt", cnt_a, 2);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
